// File: rtl/ixu_pkg.sv
// Shared types, encodings and small helpers for the IXU decode stage.
package ixu_pkg;

  localparam int IXU_OP_W  = 4;
  localparam int IXU_IMM_W = 12;

  typedef enum logic [IXU_OP_W-1:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_XOR     = 4'h2,
    OP_OR      = 4'h3,
    OP_AND     = 4'h4,
    OP_SLL     = 4'h5,
    OP_SRL     = 4'h6,
    OP_SRA     = 4'h7,
    OP_SLT     = 4'h8,
    OP_SLTU    = 4'h9,
    OP_ILLEGAL = 4'hF
  } ixu_op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } ixu_buf_state_e;

  localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef struct packed {
    ixu_op_e               op;
    logic                  is_nop;
    logic                  is_imm;
    logic                  illegal;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [IXU_IMM_W-1:0]  imm;
  } ixu_lane_dec_t;

  // Base (funct7 = 0) ALU meaning of funct3, shared by R-type and I-type.
  function automatic ixu_op_e op_from_funct3(input logic [2:0] funct3);
    ixu_op_e op;
    case (funct3)
      3'd0:    op = OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLTU;
      3'd4:    op = OP_XOR;
      3'd5:    op = OP_SRL;
      3'd6:    op = OP_OR;
      3'd7:    op = OP_AND;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ixu_lane_decode.sv
// Combinational decode of one RV32 ALU instruction slot into IXU fields.
module ixu_lane_decode
  import ixu_pkg::*;
(
  input  logic [31:0]   inst,
  output ixu_lane_dec_t dec
);

  logic [6:0]    opcode_s;
  logic [6:0]    funct7_s;
  logic [2:0]    funct3_s;
  logic          bad_s;
  ixu_lane_dec_t raw_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign funct7_s = inst[31:25];

  // Field extraction and legality check per opcode class.
  always_comb begin
    raw_s = '0;
    bad_s = 1'b0;
    if (inst == 32'd0) begin
      raw_s.is_nop = 1'b1;
    end else if (opcode_s == OPC_RTYPE) begin
      raw_s.rs1 = inst[19:15];
      raw_s.rs2 = inst[24:20];
      raw_s.rd  = inst[11:7];
      if (funct7_s == FUNCT7_BASE) begin
        raw_s.op = op_from_funct3(funct3_s);
      end else if (funct7_s == FUNCT7_ALT && funct3_s == 3'd0) begin
        raw_s.op = OP_SUB;
      end else if (funct7_s == FUNCT7_ALT && funct3_s == 3'd5) begin
        raw_s.op = OP_SRA;
      end else begin
        bad_s = 1'b1;
      end
    end else if (opcode_s == OPC_ITYPE) begin
      raw_s.rs1    = inst[19:15];
      raw_s.rd     = inst[11:7];
      raw_s.imm    = inst[31:20];
      raw_s.is_imm = 1'b1;
      // Shift-immediates reuse imm[11:5] as a funct7; there is no SUBI.
      case (funct3_s)
        3'd1: begin
          raw_s.op = OP_SLL;
          if (funct7_s != FUNCT7_BASE) bad_s = 1'b1;
          else bad_s = 1'b0;
        end
        3'd5: begin
          if (funct7_s == FUNCT7_BASE) raw_s.op = OP_SRL;
          else if (funct7_s == FUNCT7_ALT) raw_s.op = OP_SRA;
          else bad_s = 1'b1;
        end
        default: raw_s.op = op_from_funct3(funct3_s);
      endcase
    end else begin
      bad_s = 1'b1;
    end
  end

  // Illegal lanes collapse to a flagged bubble with all fields cleared.
  always_comb begin
    dec = raw_s;
    if (bad_s) begin
      dec         = '0;
      dec.op      = OP_ILLEGAL;
      dec.is_nop  = 1'b1;
      dec.illegal = 1'b1;
    end else begin
      dec = raw_s;
    end
  end

endmodule

// File: rtl/ixu_decode_stage.sv
// Registered multi-lane IXU decode stage with a two-entry skid buffer
// and a saturating count of accepted illegal lanes.
module ixu_decode_stage
  import ixu_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int IMM_W     = 12,
  parameter int OP_W      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LANES*32-1:0]    in_bundle,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*OP_W-1:0]  out_op,
  output logic [NUM_LANES-1:0]       out_is_nop,
  output logic [NUM_LANES-1:0]       out_is_imm,
  output logic [NUM_LANES*5-1:0]     out_rs1,
  output logic [NUM_LANES*5-1:0]     out_rs2,
  output logic [NUM_LANES*5-1:0]     out_rd,
  output logic [NUM_LANES*IMM_W-1:0] out_imm,
  output logic [NUM_LANES-1:0]       out_illegal,
  output logic [CNT_W-1:0]           illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ixu_buf_state_e       state_r;
  ixu_buf_state_e       state_next_s;
  ixu_lane_dec_t        dec_s  [NUM_LANES];
  ixu_lane_dec_t        main_r [NUM_LANES];
  ixu_lane_dec_t        skid_r [NUM_LANES];
  logic [NUM_LANES-1:0] dec_illegal_s;
  logic                 accept_s;
  logic                 deliver_s;
  logic                 load_main_s;
  logic                 main_from_skid_s;
  logic                 load_skid_s;
  logic [3:0]           illegal_pop_s;
  logic [CNT_W:0]       count_sum_s;
  logic [CNT_W-1:0]     illegal_count_r;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ixu_lane_decode u_lane_decode (
      .inst (in_bundle[32*g +: 32]),
      .dec  (dec_s[g])
    );

    assign dec_illegal_s[g]            = dec_s[g].illegal;
    assign out_op[g*OP_W +: OP_W]      = OP_W'(main_r[g].op);
    assign out_is_nop[g]               = main_r[g].is_nop;
    assign out_is_imm[g]               = main_r[g].is_imm;
    assign out_illegal[g]              = main_r[g].illegal;
    assign out_rs1[g*5 +: 5]           = main_r[g].rs1;
    assign out_rs2[g*5 +: 5]           = main_r[g].rs2;
    assign out_rd[g*5 +: 5]            = main_r[g].rd;
    assign out_imm[g*IMM_W +: IMM_W]   = IMM_W'(main_r[g].imm);
  end

  assign accept_s      = in_valid & in_ready & ~flush;
  assign deliver_s     = out_valid & out_ready;
  assign illegal_pop_s = popcount8(8'(dec_illegal_s));
  assign count_sum_s   = {1'b0, illegal_count_r} + (CNT_W+1)'(illegal_pop_s);
  assign illegal_count = illegal_count_r;

  // Buffer occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BUF_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy from accept/deliver; flush empties unconditionally.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = BUF_EMPTY;
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          if (accept_s) state_next_s = BUF_ONE;
          else state_next_s = BUF_EMPTY;
        end
        BUF_ONE: begin
          if (accept_s && !deliver_s) state_next_s = BUF_TWO;
          else if (!accept_s && deliver_s) state_next_s = BUF_EMPTY;
          else state_next_s = BUF_ONE;
        end
        BUF_TWO: begin
          if (deliver_s) state_next_s = BUF_ONE;
          else state_next_s = BUF_TWO;
        end
        default: state_next_s = BUF_EMPTY;
      endcase
    end
  end

  // Handshake outputs depend on occupancy only, keeping in_ready off the out_ready path.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      BUF_EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
      BUF_ONE:   begin in_ready = 1'b1; out_valid = 1'b1; end
      BUF_TWO:   begin in_ready = 1'b0; out_valid = 1'b1; end
      default:   begin in_ready = 1'b1; out_valid = 1'b0; end
    endcase
  end

  // Entry load controls: main always holds the oldest undelivered bundle.
  always_comb begin
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      load_main_s = 1'b0;
    end else begin
      case (state_r)
        BUF_EMPTY: load_main_s = accept_s;
        BUF_ONE: begin
          load_main_s = accept_s & deliver_s;
          load_skid_s = accept_s & ~deliver_s;
        end
        BUF_TWO: begin
          load_main_s      = deliver_s;
          main_from_skid_s = 1'b1;
        end
        default: load_main_s = 1'b0;
      endcase
    end
  end

  // Main and skid entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        main_r[i] <= '0;
        skid_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (load_main_s) main_r[i] <= main_from_skid_s ? skid_r[i] : dec_s[i];
        if (load_skid_s) skid_r[i] <= dec_s[i];
      end
    end
  end

  // Saturating illegal-lane counter; the carry-out bit marks overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count_r <= '0;
    end else if (accept_s) begin
      illegal_count_r <= count_sum_s[CNT_W] ? CNT_MAX : count_sum_s[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_ixu_decode_stage.sv
// Self-checking bench for ixu_decode_stage: directed scenarios plus a
// randomized stream checked against a queue-based behavioural model.
module tb_ixu_decode_stage;

  localparam int NL = 2;

  typedef struct packed {
    logic [3:0]  op;
    logic        nop;
    logic        isimm;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [NL*32-1:0] in_bundle;
  logic [NL*4-1:0]  out_op;
  logic [NL-1:0]    out_is_nop, out_is_imm, out_illegal;
  logic [NL*5-1:0]  out_rs1, out_rs2, out_rd;
  logic [NL*12-1:0] out_imm;
  logic [15:0]      illegal_count;

  int checks = 0;
  int errors = 0;

  ixu_decode_stage #(.NUM_LANES(NL), .IMM_W(12), .OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_bundle(in_bundle), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_is_nop(out_is_nop), .out_is_imm(out_is_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // RV32 base ALU meaning of funct3: ADD SLL SLT SLTU XOR SRL OR AND.
  function automatic logic [3:0] f3_op(input int f3);
    case (f3)
      0: return 4'd0;
      1: return 4'd5;
      2: return 4'd8;
      3: return 4'd9;
      4: return 4'd2;
      5: return 4'd6;
      6: return 4'd3;
      default: return 4'd4;
    endcase
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int opc, f3, f7;
    bit ok;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    e   = '0;
    ok  = 1'b0;
    if (w == 32'd0) begin
      e.nop = 1'b1;
      return e;
    end
    if (opc == 51) begin
      e.rs2 = w[24:20];
      if (f7 == 0) begin ok = 1'b1; e.op = f3_op(f3); end
      else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin ok = 1'b1; e.op = (f3 == 0) ? 4'd1 : 4'd7; end
    end else if (opc == 19) begin
      e.isimm = 1'b1;
      e.imm   = w[31:20];
      if (f3 == 1) begin ok = (f7 == 0); e.op = 4'd5; end
      else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); e.op = (f7 == 0) ? 4'd6 : 4'd7; end
      else begin ok = 1'b1; e.op = f3_op(f3); end
    end
    if (!ok) begin
      e = '0; e.op = 4'hF; e.nop = 1'b1; e.ill = 1'b1;
    end else begin
      e.rs1 = w[19:15]; e.rd = w[11:7];
    end
    return e;
  endfunction

  function automatic exp_t dut_lane(input int l);
    return {out_op[4*l +: 4], out_is_nop[l], out_is_imm[l], out_illegal[l],
            out_rs1[5*l +: 5], out_rs2[5*l +: 5], out_rd[5*l +: 5], out_imm[12*l +: 12]};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k, k2;
    w  = $urandom;
    k  = $urandom_range(0, 7);
    k2 = $urandom_range(0, 2);
    case (k)
      0:       w = 32'd0;
      1, 2:    begin w[6:0] = 7'h33; w[31:25] = (k2 == 0) ? 7'h00 : (k2 == 1) ? 7'h20 : w[31:25]; end
      3, 4, 5: begin w[6:0] = 7'h13; if (k2 != 2) w[31:25] = (k2 == 0) ? 7'h00 : 7'h20; end
      default: ;
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bundle = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bundle = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++;
    if ({out_op, out_is_nop, out_is_imm, out_illegal, out_rs1, out_rs2, out_rd, out_imm} !== '0) begin
      errors++; $display("FAIL reset_fields got op=%h rd=%h imm=%h nop=%b exp all zero", out_op, out_rd, out_imm, out_is_nop);
    end
    checks++;
    if (illegal_count !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", illegal_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    in_bundle = {32'h407302B3, 32'h002081B3}; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_op !== 8'h10) begin
      errors++; $display("FAIL rtype_op got valid=%b op=%h exp valid=1 op=10", out_valid, out_op);
    end
    checks++;
    if (out_rs1 !== {5'd6, 5'd1} || out_rs2 !== {5'd7, 5'd2} || out_rd !== {5'd5, 5'd3}) begin
      errors++; $display("FAIL rtype_regs got rs1=%h rs2=%h rd=%h exp 0c1 0e2 0a3", out_rs1, out_rs2, out_rd);
    end
    checks++;
    if (out_illegal !== 2'b00 || out_is_imm !== 2'b00 || out_is_nop !== 2'b00) begin
      errors++; $display("FAIL rtype_flags got ill=%b imm=%b nop=%b exp 00 00 00", out_illegal, out_is_imm, out_is_nop);
    end
  endtask

  task automatic test_itype_nop();
    in_bundle = {32'h00000000, 32'h40315093}; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++;
    if (out_op !== 8'h07 || out_is_imm !== 2'b01 || out_imm !== {12'h000, 12'h403}) begin
      errors++; $display("FAIL srai_fields got op=%h isimm=%b imm=%h exp 07 01 000403", out_op, out_is_imm, out_imm);
    end
    checks++;
    if (out_rs1 !== {5'd0, 5'd2} || out_rd !== {5'd0, 5'd1} || out_rs2 !== 10'd0) begin
      errors++; $display("FAIL srai_regs got rs1=%h rd=%h rs2=%h exp 002 001 000", out_rs1, out_rd, out_rs2);
    end
    checks++;
    if (out_is_nop !== 2'b10 || out_illegal !== 2'b00) begin
      errors++; $display("FAIL nop_lane got nop=%b ill=%b exp 10 00", out_is_nop, out_illegal);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen [$];
    out_ready = 1'b0; in_valid = 1'b1;
    in_bundle = {32'h0, 32'h00100513};
    step();
    checks++;
    if (in_ready !== 1'b1 || out_rd[4:0] !== 5'd10) begin
      errors++; $display("FAIL b2b_a got ready=%b rd=%0d exp 1 10", in_ready, out_rd[4:0]);
    end
    in_bundle = {32'h0, 32'h00100593};
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd[4:0] !== 5'd10) begin
      errors++; $display("FAIL b2b_full got ready=%b valid=%b rd=%0d exp 0 1 10", in_ready, out_valid, out_rd[4:0]);
    end
    in_bundle = {32'h0, 32'h00100613};
    step();
    checks++;
    if (in_ready !== 1'b0 || out_rd[4:0] !== 5'd10) begin
      errors++; $display("FAIL b2b_hold got ready=%b rd=%0d exp 0 10", in_ready, out_rd[4:0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) in_valid = 1'b0;
      if (out_valid === 1'b1) seen.push_back(out_rd[4:0]);
      step();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 5'd10 || seen[1] !== 5'd11 || seen[2] !== 5'd12 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_order got n=%0d seq=%p valid=%b exp n=3 seq 10,11,12 valid=0", seen.size(), seen, out_valid);
    end
  endtask

  task automatic test_illegal_sat();
    do_reset();
    in_bundle = {32'h0000007F, 32'h022081B3}; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++;
    if (out_illegal !== 2'b11 || out_op !== 8'hFF || out_is_nop !== 2'b11) begin
      errors++; $display("FAIL illegal_flags got ill=%b op=%h nop=%b exp 11 ff 11", out_illegal, out_op, out_is_nop);
    end
    checks++;
    if ({out_rs1, out_rs2, out_rd, out_imm, out_is_imm} !== '0) begin
      errors++; $display("FAIL illegal_zero got rs1=%h rd=%h imm=%h exp 0", out_rs1, out_rd, out_imm);
    end
    checks++;
    if (illegal_count !== 16'd2) begin
      errors++; $display("FAIL illegal_count got %0d exp 2", illegal_count);
    end
    repeat (32766) step();
    checks++;
    if (illegal_count !== 16'd65534) begin
      errors++; $display("FAIL count_fill got %0d exp 65534", illegal_count);
    end
    in_bundle = {32'h00000000, 32'h0000007F};
    step();
    checks++;
    if (illegal_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_top got %h exp ffff", illegal_count);
    end
    in_bundle = {32'h0000007F, 32'h0000007F};
    step();
    checks++;
    if (illegal_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_sat got %h exp ffff", illegal_count);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    in_bundle = {32'h0, 32'h00100513};
    step();
    in_bundle = {32'h0, 32'h00100593};
    step();
    in_bundle = {32'h0000007F, 32'h0000007F}; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || illegal_count !== 16'd0) begin
      errors++; $display("FAIL flush_gone got valid=%b count=%0d exp 0 0", out_valid, illegal_count);
    end
    in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || illegal_count !== 16'd0) begin
      errors++; $display("FAIL flush_drop got valid=%b count=%0d exp 0 0", out_valid, illegal_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_bundle = {32'h0000007F, 32'h002081B3}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || illegal_count !== 16'd1) begin
      errors++; $display("FAIL areset_pre got valid=%b count=%0d exp 1 1", out_valid, illegal_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 16'd0 ||
        {out_op, out_is_nop, out_illegal, out_rs1, out_rs2, out_rd} !== '0) begin
      errors++; $display("FAIL areset_now got valid=%b ready=%b count=%0d op=%h rd=%h exp 0 1 0 0 0",
                         out_valid, in_ready, illegal_count, out_op, out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_bundle = {32'h00000000, 32'h002081B3}; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op[3:0] !== 4'd0 || out_rd[4:0] !== 5'd3 ||
        out_rs1[4:0] !== 5'd1 || out_rs2[4:0] !== 5'd2 || out_illegal !== 2'b00) begin
      errors++; $display("FAIL areset_post got valid=%b op=%h rd=%h rs1=%h rs2=%h ill=%b exp 1 0 3 1 2 00",
                         out_valid, out_op, out_rd, out_rs1, out_rs2, out_illegal);
    end
    step();
  endtask

  task automatic test_random();
    logic [NL*32-1:0] q [$];
    int mcnt, nill;
    bit acc, dlv;
    exp_t e, g;
    do_reset();
    mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_hs cyc=%0d got valid=%b ready=%b exp occupancy %0d", c, out_valid, in_ready, q.size());
      end
      checks++;
      if (illegal_count !== 16'(mcnt)) begin
        errors++; $display("FAIL rand_count cyc=%0d got %0d exp %0d", c, illegal_count, mcnt);
      end
      if (q.size() > 0) begin
        for (int l = 0; l < NL; l++) begin
          e = ref_dec(q[0][32*l +: 32]);
          g = dut_lane(l);
          checks++;
          if (g !== e) begin
            errors++; $display("FAIL rand_lane%0d cyc=%0d inst=%h got=%h exp=%h", l, c, q[0][32*l +: 32], g, e);
          end
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_bundle = {rand_inst(), rand_inst()};
      @(posedge clk);
      acc = in_valid && (q.size() < 2) && !flush;
      dlv = (q.size() > 0) && out_ready;
      nill = 0;
      for (int l = 0; l < NL; l++) nill += int'(ref_dec(in_bundle[32*l +: 32]).ill);
      if (flush) q.delete();
      else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(in_bundle);
      end
      if (acc) mcnt = (mcnt + nill > 65535) ? 65535 : mcnt + nill;
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype_nop();
    test_back_to_back();
    test_illegal_sat();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
